fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage RV64 pipeline; feeds the DE latch (DE_NPC, DE_IR, DE_V) consumed by decode.
- Owns the PC. Issues single-outstanding requests to instruction memory and buffers one returned word.
- Stalls for MEM_STALL and for unresolved conditional branches flagged by decode.
- Redirects on branch resolution from execute and on trap entry (WB_CS) to DE_MTVEC.

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch.sv | 150 +++++++++++++++
 tb/tb_fetch.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Single outstanding request; the response arrives one or more cycles after acceptance.
interface fetch_if;
  logic        imem_req_v;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_resp_v;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req_v,
    output imem_addr,
    input  imem_ready,
    input  imem_resp_v,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_v,
    input  imem_addr,
    output imem_ready,
    output imem_resp_v,
    output imem_rdata
  );
endinterface

// File: rtl/fetch.sv
// RV64 instruction-fetch stage: owns the PC, keeps one imem request in flight,
// buffers one returned word and loads the DE latch for decode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | request driven at PC, waiting for imem_ready
// ST_WAIT  | request accepted, waiting for the response
// ST_HOLD  | response captured in ibuf, waiting to enter DE
// ST_DRAIN | request accepted but redirected; drop its response
module fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  fetch_if.master     imem,
  input  logic        MEM_STALL,
  input  logic        v_de_br_stall,
  input  logic        BR_RESOLVED,
  input  logic        BR_TAKEN,
  input  logic [63:0] BR_TARGET,
  input  logic        WB_CS,
  input  logic [63:0] DE_MTVEC,
  output logic [63:0] DE_NPC,
  output logic [31:0] DE_IR,
  output logic        DE_V
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic        req_v;
  logic [63:0] pc;
  logic [31:0] ibuf;
  logic        br_pending;

  logic        redirect;
  logic        br_block;
  logic        word_avail;
  logic [31:0] word;
  logic        deliver;
  logic        accept;
  logic [63:0] pc_plus4;
  logic [63:0] redirect_pc;

  assign imem.imem_req_v = req_v;
  assign imem.imem_addr  = pc;

  assign redirect    = WB_CS | (BR_RESOLVED & BR_TAKEN);
  assign br_block    = br_pending | (DE_V & v_de_br_stall);
  assign word_avail  = ((state == ST_WAIT) & imem.imem_resp_v) | (state == ST_HOLD);
  assign word        = (state == ST_HOLD) ? ibuf : imem.imem_rdata;
  // A same-cycle redirect also blocks delivery so a wrong-path word never reaches DE.
  assign deliver     = word_avail & ~MEM_STALL & ~br_block & ~redirect;
  assign accept      = req_v & imem.imem_ready;
  assign pc_plus4    = pc + 64'd4;
  assign redirect_pc = (WB_CS ? DE_MTVEC : BR_TARGET) & ~64'h3;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
      req_v <= 1'b0;
      ibuf  <= 32'd0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (accept) begin
            state <= redirect ? ST_DRAIN : ST_WAIT;
            req_v <= 1'b0;
          end else begin
            req_v <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem.imem_resp_v) begin
            if (redirect || deliver) begin
              state <= ST_FETCH;
              req_v <= 1'b1;
            end else begin
              state <= ST_HOLD;
              ibuf  <= imem.imem_rdata;
            end
          end else if (redirect) begin
            state <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (redirect || deliver) begin
            state <= ST_FETCH;
            req_v <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (imem.imem_resp_v) begin
            state <= ST_FETCH;
            req_v <= 1'b1;
          end
        end
        default: begin
          state <= ST_FETCH;
          req_v <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC & ~64'h3;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (deliver) begin
      pc <= pc_plus4;
    end
  end

  // A branch leaving DE keeps fetch blocked until execute resolves it.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      br_pending <= 1'b0;
    end else if (WB_CS) begin
      br_pending <= 1'b0;
    end else if (DE_V && v_de_br_stall && !MEM_STALL) begin
      br_pending <= 1'b1;
    end else if (BR_RESOLVED) begin
      br_pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      DE_V   <= 1'b0;
      DE_IR  <= 32'd0;
      DE_NPC <= 64'd0;
    end else if (WB_CS) begin
      DE_V <= 1'b0;
    end else if (!MEM_STALL) begin
      DE_V <= deliver;
      if (deliver) begin
        DE_IR  <= word;
        DE_NPC <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: imem model, expected fetch/DE scoreboards,
// a cycle table for straight-line/stall/ready timing and hand sequences for redirects.
module tb_fetch;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        CLK;
  logic        reset;
  logic        MEM_STALL;
  logic        v_de_br_stall;
  logic        BR_RESOLVED;
  logic        BR_TAKEN;
  logic [63:0] BR_TARGET;
  logic        WB_CS;
  logic [63:0] DE_MTVEC;
  logic [63:0] DE_NPC;
  logic [31:0] DE_IR;
  logic        DE_V;

  fetch_if imem();

  fetch #(.RESET_PC(RESET_PC)) u_dut (
    .CLK          (CLK),
    .reset        (reset),
    .imem         (imem),
    .MEM_STALL    (MEM_STALL),
    .v_de_br_stall(v_de_br_stall),
    .BR_RESOLVED  (BR_RESOLVED),
    .BR_TAKEN     (BR_TAKEN),
    .BR_TARGET    (BR_TARGET),
    .WB_CS        (WB_CS),
    .DE_MTVEC     (DE_MTVEC),
    .DE_NPC       (DE_NPC),
    .DE_IR        (DE_IR),
    .DE_V         (DE_V)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] npc;
    logic [31:0] ir;
  } de_t;

  typedef struct {
    logic stall;
    logic ready;
    logic exp_req;
    logic exp_dev;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  de_t         exp_de[$];
  logic [63:0] exp_fetch[$];
  int          lat;
  int          cnt;
  logic [63:0] resp_addr;
  logic [63:0] br_addr;
  vec_t        tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%h required=none t=%0t", name, act, $time);
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a == br_addr) return 32'h0040_0063;
    return {a[25:2], 8'h13};
  endfunction

  function automatic de_t de_of(input logic [63:0] a);
    de_t d;
    d.npc = a + 64'd4;
    d.ir  = word_at(a);
    return d;
  endfunction

  // One clock: handshake check before the edge, DE monitor and imem model after it.
  task automatic tick();
    logic        hs_now;
    logic [63:0] a;
    logic [63:0] ea;
    de_t         e;
    hs_now = imem.imem_req_v && imem.imem_ready;
    a      = imem.imem_addr;
    if (hs_now) begin
      chk("addr_align", {62'd0, a[1:0]}, 64'd0);
      if (exp_fetch.size() == 0) note_fail("unexpected_fetch", a);
      else begin
        ea = exp_fetch.pop_front();
        chk("fetch_addr", a, ea);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    if (DE_V && !MEM_STALL) begin
      if (exp_de.size() == 0) note_fail("unexpected_de", DE_NPC);
      else begin
        e = exp_de.pop_front();
        chk("de_npc", DE_NPC, e.npc);
        chk("de_ir", {32'd0, DE_IR}, {32'd0, e.ir});
      end
    end
    imem.imem_resp_v = 1'b0;
    if (hs_now) begin
      cnt       = lat;
      resp_addr = a;
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem.imem_resp_v = 1'b1;
        imem.imem_rdata  = word_at(resp_addr);
      end
    end
    v_de_br_stall = (DE_IR[6:0] == 7'h63);
  endtask

  task automatic check_reset_vals();
    chk("rst_de_v", {63'd0, DE_V}, 64'd0);
    chk("rst_de_ir", {32'd0, DE_IR}, 64'd0);
    chk("rst_de_npc", DE_NPC, 64'd0);
    chk("rst_req_v", {63'd0, imem.imem_req_v}, 64'd0);
    chk("rst_addr", imem.imem_addr, RESET_PC);
  endtask

  // Asserts reset now, clears bench-side state, checks outputs, releases on a later negedge.
  task automatic apply_reset();
    reset            = 1'b0;
    MEM_STALL        = 1'b0;
    v_de_br_stall    = 1'b0;
    BR_RESOLVED      = 1'b0;
    BR_TAKEN         = 1'b0;
    BR_TARGET        = 64'd0;
    WB_CS            = 1'b0;
    DE_MTVEC         = 64'd0;
    imem.imem_ready  = 1'b1;
    imem.imem_resp_v = 1'b0;
    imem.imem_rdata  = 32'd0;
    cnt              = 0;
    br_addr          = 64'd0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic run_until_empty(input string name, input int max);
    int n;
    n = 0;
    while ((exp_fetch.size() != 0 || exp_de.size() != 0) && n < max) begin
      tick();
      n++;
    end
    chk({name, "_fetch_left"}, 64'(exp_fetch.size()), 64'd0);
    chk({name, "_de_left"}, 64'(exp_de.size()), 64'd0);
  endtask

  task automatic run_branch(input logic taken);
    string tag;
    tag = taken ? "br_taken" : "br_not_taken";
    @(negedge CLK);
    apply_reset();
    lat     = 1;
    br_addr = RESET_PC + 64'h10;
    for (int i = 0; i < 6; i++) exp_fetch.push_back(RESET_PC + 64'(4 * i));
    for (int i = 0; i < 5; i++) exp_de.push_back(de_of(RESET_PC + 64'(4 * i)));
    if (taken) begin
      exp_fetch.push_back(RESET_PC + 64'h100);
      exp_de.push_back(de_of(RESET_PC + 64'h100));
    end else begin
      exp_fetch.push_back(RESET_PC + 64'h18);
      exp_de.push_back(de_of(RESET_PC + 64'h14));
    end
    repeat (11) tick();
    chk({tag, "_branch_in_de"}, {63'd0, DE_V}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_blocked_dev"}, {63'd0, DE_V}, 64'd0);
      chk({tag, "_blocked_req"}, {63'd0, imem.imem_req_v}, 64'd0);
    end
    BR_RESOLVED = 1'b1;
    BR_TAKEN    = taken;
    BR_TARGET   = RESET_PC + 64'h103;
    tick();
    BR_RESOLVED = 1'b0;
    BR_TAKEN    = 1'b0;
    chk({tag, "_resolve_dev"}, {63'd0, DE_V}, 64'd0);
    if (taken) begin
      chk({tag, "_target_req"}, {63'd0, imem.imem_req_v}, 64'd1);
      chk({tag, "_target_addr"}, imem.imem_addr, RESET_PC + 64'h100);
    end else begin
      chk({tag, "_no_refetch"}, {63'd0, imem.imem_req_v}, 64'd0);
      tick();
      chk({tag, "_held_delivered"}, {63'd0, DE_V}, 64'd1);
    end
    run_until_empty(tag, 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b1, exp_dev: 1'b0};
    tbl[1]  = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b0, exp_dev: 1'b0};
    tbl[2]  = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b1, exp_dev: 1'b1};
    tbl[3]  = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b0, exp_dev: 1'b0};
    tbl[4]  = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b1, exp_dev: 1'b1};
    tbl[5]  = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b0, exp_dev: 1'b0};
    tbl[6]  = '{stall: 1'b1, ready: 1'b1, exp_req: 1'b1, exp_dev: 1'b1};
    tbl[7]  = '{stall: 1'b1, ready: 1'b1, exp_req: 1'b0, exp_dev: 1'b1};
    tbl[8]  = '{stall: 1'b1, ready: 1'b1, exp_req: 1'b0, exp_dev: 1'b1};
    tbl[9]  = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b0, exp_dev: 1'b1};
    tbl[10] = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b1, exp_dev: 1'b1};
    tbl[11] = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b0, exp_dev: 1'b0};
    tbl[12] = '{stall: 1'b0, ready: 1'b0, exp_req: 1'b1, exp_dev: 1'b1};
    tbl[13] = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b1, exp_dev: 1'b0};
    tbl[14] = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b0, exp_dev: 1'b0};
    tbl[15] = '{stall: 1'b0, ready: 1'b1, exp_req: 1'b1, exp_dev: 1'b1};

    reset   = 1'b1;
    lat     = 1;
    cnt     = 0;
    br_addr = 64'd0;
    @(negedge CLK);
    apply_reset();

    // Straight-line fetch with a 3-cycle DE stall and one cycle of imem back-pressure.
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      exp_fetch.push_back(RESET_PC + 64'(4 * i));
      exp_de.push_back(de_of(RESET_PC + 64'(4 * i)));
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("tbl%0d_req", k + 1), {63'd0, imem.imem_req_v}, {63'd0, tbl[k].exp_req});
      chk($sformatf("tbl%0d_dev", k + 1), {63'd0, DE_V}, {63'd0, tbl[k].exp_dev});
      MEM_STALL       = tbl[k].stall;
      imem.imem_ready = tbl[k].ready;
    end
    chk("line_fetch_left", 64'(exp_fetch.size()), 64'd0);
    chk("line_de_left", 64'(exp_de.size()), 64'd0);

    run_branch(1'b1);
    run_branch(1'b0);

    // Trap entry while waiting on a 3-cycle memory, with DE stalled.
    @(negedge CLK);
    apply_reset();
    lat = 3;
    exp_fetch.push_back(RESET_PC);
    exp_fetch.push_back(RESET_PC + 64'h4);
    exp_fetch.push_back(RESET_PC + 64'h200);
    exp_de.push_back(de_of(RESET_PC));
    exp_de.push_back(de_of(RESET_PC + 64'h200));
    repeat (5) tick();
    chk("trap_first_dev", {63'd0, DE_V}, 64'd1);
    MEM_STALL = 1'b1;
    tick();
    chk("trap_stall_hold", {63'd0, DE_V}, 64'd1);
    WB_CS    = 1'b1;
    DE_MTVEC = RESET_PC + 64'h201;
    tick();
    chk("trap_flush_dev", {63'd0, DE_V}, 64'd0);
    chk("trap_drain_req", {63'd0, imem.imem_req_v}, 64'd0);
    WB_CS     = 1'b0;
    MEM_STALL = 1'b0;
    tick();
    chk("trap_drain_req2", {63'd0, imem.imem_req_v}, 64'd0);
    chk("trap_drain_dev", {63'd0, DE_V}, 64'd0);
    tick();
    chk("trap_vec_req", {63'd0, imem.imem_req_v}, 64'd1);
    chk("trap_vec_addr", imem.imem_addr, RESET_PC + 64'h200);
    chk("trap_vec_dev", {63'd0, DE_V}, 64'd0);
    run_until_empty("trap", 30);

    // Reset asserted mid-WAIT; outputs must clear without a clock edge.
    @(negedge CLK);
    apply_reset();
    lat = 3;
    exp_fetch.push_back(RESET_PC);
    exp_fetch.push_back(RESET_PC + 64'h4);
    exp_de.push_back(de_of(RESET_PC));
    repeat (5) tick();
    MEM_STALL = 1'b1;
    tick();
    chk("midrst_pre_dev", {63'd0, DE_V}, 64'd1);
    chk("midrst_pre_addr", imem.imem_addr, RESET_PC + 64'h4);
    #2;
    apply_reset();
    chk("midrst_fetch_left", 64'(exp_fetch.size()), 64'd0);
    chk("midrst_de_left", 64'(exp_de.size()), 64'd0);
    lat = 3;
    exp_fetch.push_back(RESET_PC);
    exp_de.push_back(de_of(RESET_PC));
    tick();
    chk("midrst_first_req", {63'd0, imem.imem_req_v}, 64'd1);
    chk("midrst_first_addr", imem.imem_addr, RESET_PC);
    run_until_empty("midrst", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
